// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between two requesters; reads return via rvalid pulse.
// Define BRAM_ARB_FIXED_PRIO_EN to make requester 0 always win ties (requester 1 may starve).
module bram_port_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_q,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StRdRet} state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              win_q, win_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_data_q, bram_data_d;
  logic              bram_we_q, bram_we_d;
  logic              pick;

  // Winner if arbitration happens this cycle: 0 = requester 0, 1 = requester 1.
  always_comb begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
    pick = ~req0;
`else
    if (req0 && req1) begin
      pick = ~last_gnt_q;
    end else begin
      pick = ~req0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    win_d       = win_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata_d     = rdata_q;
    bram_addr_d = bram_addr_q;
    bram_data_d = bram_data_q;
    bram_we_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          win_d       = pick;
          last_gnt_d  = pick;
          gnt0_d      = ~pick;
          gnt1_d      = pick;
          bram_addr_d = pick ? addr1 : addr0;
          bram_data_d = pick ? wdata1 : wdata0;
          bram_we_d   = pick ? we1 : we0;
          state_d     = StAccess;
        end
      end
      StAccess: begin
        state_d = bram_we_q ? StIdle : StRdWait;
      end
      StRdWait: begin
        // BRAM output reflects the address presented during StAccess.
        rdata_d   = bram_q;
        rvalid0_d = ~win_q;
        rvalid1_d = win_q;
        state_d   = StRdRet;
      end
      StRdRet: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      last_gnt_q  <= 1'b1;
      win_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata_q     <= '0;
      bram_addr_q <= '0;
      bram_data_q <= '0;
      bram_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      win_q       <= win_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata_q     <= rdata_d;
      bram_addr_q <= bram_addr_d;
      bram_data_q <= bram_data_d;
      bram_we_q   <= bram_we_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign bram_addr = bram_addr_q;
  assign bram_data = bram_data_q;
  assign bram_we   = bram_we_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
Two-requester arbiter that shares port A of the team's dual-port BRAM between the CPU instruction-fetch path and the load/store path. Each requester supplies a complete access (address, write enable, write data). The arbiter selects one requester round-robin and drives the BRAM port A signals from registers. For reads it captures the BRAM output and returns it with a one-cycle valid pulse. It replaces hand-sequenced BRAM address and write-enable stepping with a request/grant handshake.

Parameters:
DATA_W, 16, width of BRAM word and requester data
ADDR_W, 10, width of BRAM address

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 access request; held until gnt0 seen
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  one-cycle grant pulse to requester 0
rvalid0  output  1  one-cycle read-data-valid pulse to requester 0
req1  input  1  requester 1 access request
we1  input  1  requester 1: 1 = write, 0 = read
addr1  input  ADDR_W  requester 1 address
wdata1  input  DATA_W  requester 1 write data
gnt1  output  1  one-cycle grant pulse to requester 1
rvalid1  output  1  one-cycle read-data-valid pulse to requester 1
rdata  output  DATA_W  read data; shared by both requesters, qualified by rvalid0/rvalid1
bram_addr  output  ADDR_W  to BRAM addr_a
bram_data  output  DATA_W  to BRAM data_a
bram_we  output  1  to BRAM we_a
bram_q  input  DATA_W  from BRAM q_a; synchronous read, valid the cycle after address is presented
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, reset=1 at rising edge):
  - state=IDLE; all outputs 0.
  - last_gnt=1, so requester 0 wins the first tie.
  - Any in-flight access is abandoned: no rvalid, bram_we=0 from the next cycle.
- States: IDLE, ACCESS, RDWAIT, RDRET.
- IDLE:
  - No req high: stay in IDLE.
  - One req high: that requester wins.
  - Both high: the requester != last_gnt wins.
  - On win, register bram_addr/bram_data/bram_we from the winner's addr/wdata/we. Set gnt<winner>=1 and last_gnt=winner. Go to ACCESS.
- ACCESS (1 cycle):
  - gnt<winner> high; BRAM samples address/write at the end of this cycle.
  - Write: go to IDLE.
  - Read: go to RDWAIT.
- RDWAIT (1 cycle): bram_we=0; at the end of this cycle rdata <= bram_q; go to RDRET.
- RDRET (1 cycle): rvalid<winner>=1, rdata holds the read word; go to IDLE.
- rdata holds its last value until the next read capture.
- bram_addr/bram_data hold their last value outside ACCESS; bram_we=1 only in ACCESS with a write winner.
- Handshake:
  - Requester keeps req/we/addr/wdata stable from assertion until the edge where gnt is high.
  - At that edge it drops req or presents a new request.
  - req is sampled only in IDLE; requests arriving in other states wait.
- Latency from the edge that samples req in IDLE:
  - Write: gnt in the next cycle; memory updated at the end of that cycle; 2 cycles IDLE->IDLE.
  - Read: gnt at cycle +1; rvalid/rdata at cycle +3; 4 cycles IDLE->IDLE.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- gnt0&gnt1 and rvalid0&rvalid1 are never high together.
- Width rules: no arithmetic; data and address pass through unmodified.

Optional Feature:
- Macro BRAM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both requesters are high in IDLE. last_gnt is still updated but ignored. Requester 1 can starve.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset behaviour:
  - Stimulus: reset=1 for 2 cycles, then all req=0.
  - Response: every output 0, busy=0, bram_we never 1.
- Write then read, different requesters:
  - Stimulus: req0 write addr=2, wdata=24; then req1 read addr=2.
  - Response: bram_we=1 for exactly one cycle with bram_addr=2, bram_data=24, gnt0 in the same cycle. gnt1 follows. rvalid1 pulses 3 cycles after the req1 sample edge with rdata=24.
- Simultaneous requests:
  - Stimulus: req0 and req1 raised together after reset, both reads of addrs 5 and 6, re-requested immediately after each grant.
  - Response: grant order 0,1,0,1. rvalid0 returns mem[5], rvalid1 returns mem[6], never overlapping.
- Back-to-back writes:
  - Stimulus: req1 writes addrs 0..3 with data 0xA0..0xA3 while req0 idle.
  - Response: 4 gnt1 pulses 2 cycles apart; subsequent reads return 0xA0..0xA3.
- Reset mid-read:
  - Stimulus: assert reset in RDWAIT of a req0 read.
  - Response: no rvalid0 pulse; next cycle state IDLE, gnt/bram_we 0; the next tie is won by requester 0.
- Fixed priority (BRAM_ARB_FIXED_PRIO_EN defined):
  - Stimulus: req0 and req1 held high for 4 accesses.
  - Response: all 4 grants go to requester 0; gnt1 stays 0.
